// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // True for the opcodes that occupy the unit for several cycles.
  function automatic logic md_is_multicycle(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Larger of two latencies, used to size the countdown.
  function automatic int md_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational product/quotient datapath for mult_div_unit.
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo,
  output logic        o_div_by_zero
);

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;
  logic        [31:0] w_uquot;
  logic        [31:0] w_urem;
  logic               w_bzero;
  logic               w_ovf;

  assign w_bzero = (i_b == 32'h0000_0000);
  // MIN_INT / -1 does not fit; the architected answer is LO=MIN_INT, HI=0.
  assign w_ovf   = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  assign w_sprod = $signed(i_a) * $signed(i_b);
  assign w_uprod = {32'h0000_0000, i_a} * {32'h0000_0000, i_b};

  // Divide results, with the zero and overflow divisors steered away from the operators.
  always_comb begin
    w_squot = 32'sd0;
    w_srem  = 32'sd0;
    w_uquot = 32'h0000_0000;
    w_urem  = 32'h0000_0000;
    if (w_bzero) begin
      w_squot = 32'sd0;
      w_srem  = 32'sd0;
    end else if (w_ovf) begin
      w_squot = 32'sh8000_0000;
      w_srem  = 32'sd0;
    end else begin
      // Signed / and % truncate toward zero; remainder follows the dividend.
      w_squot = $signed(i_a) / $signed(i_b);
      w_srem  = $signed(i_a) % $signed(i_b);
    end
    if (w_bzero) begin
      w_uquot = 32'h0000_0000;
      w_urem  = 32'h0000_0000;
    end else begin
      w_uquot = i_a / i_b;
      w_urem  = i_a % i_b;
    end
  end

  // Select the result pair for the requested operation.
  always_comb begin
    o_res_hi      = 32'h0000_0000;
    o_res_lo      = 32'h0000_0000;
    o_div_by_zero = 1'b0;
    case (md_op_e'(i_op))
      MD_MULT:  {o_res_hi, o_res_lo} = w_sprod;
      MD_MULTU: {o_res_hi, o_res_lo} = w_uprod;
      MD_DIV: begin
        o_res_lo      = w_squot;
        o_res_hi      = w_srem;
        o_div_by_zero = w_bzero;
      end
      MD_DIVU: begin
        o_res_lo      = w_uquot;
        o_res_hi      = w_urem;
        o_div_by_zero = w_bzero;
      end
      default: begin
        o_res_hi      = 32'h0000_0000;
        o_res_lo      = 32'h0000_0000;
        o_div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, models fixed latency with a countdown.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = md_max(MULT_CYCLES, DIV_CYCLES);
  localparam int CNT_W   = md_max($clog2(MAX_CYC + 1), 4);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_dbz;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_dbz;
  logic             w_is_mul;

  assign w_is_mul = (MDOp == MD_MULT) || (MDOp == MD_MULTU);

  mdu_arith u_arith (
    .i_op          (MDOp),
    .i_a           (SrcA),
    .i_b           (SrcB),
    .o_res_hi      (w_res_hi),
    .o_res_lo      (w_res_lo),
    .o_div_by_zero (w_dbz)
  );

  // Control FSM: accept in IDLE, count down in RUN, commit pending result on the 1->0 step.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_pend_hi  <= 32'h0000_0000;
      r_pend_lo  <= 32'h0000_0000;
      r_pend_dbz <= 1'b0;
      r_busy     <= 1'b0;
      r_hi       <= 32'h0000_0000;
      r_lo       <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start && md_is_multicycle(MDOp)) begin
            r_pend_hi  <= w_res_hi;
            r_pend_lo  <= w_res_lo;
            r_pend_dbz <= w_dbz;
            r_cnt      <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            r_busy     <= 1'b1;
            r_state    <= ST_RUN;
          end else if (Start && (MDOp == MD_MTHI)) begin
            r_hi <= SrcA;
          end else if (Start && (MDOp == MD_MTLO)) begin
            r_lo <= SrcA;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // New Start requests are ignored here; the hazard unit keeps them away.
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
            // A zero divisor leaves the architectural registers untouched.
            if (!r_pend_dbz) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end else begin
              r_hi <= r_hi;
              r_lo <= r_lo;
            end
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk   (clk),
    .Reset (rst),
    .Start (start),
    .MDOp  (md_op),
    .SrcA  (src_a),
    .SrcB  (src_b),
    .Busy  (busy),
    .HI    (hi),
    .LO    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launch a multi-cycle op; optionally present a MULT Start during RUN at cycle `intrude`.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n_exp, input int intrude,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    int early;
    n = 0;
    early = 0;
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd7;
    while (busy === 1'b1 && n < 40) begin
      if (hi !== m_hi || lo !== m_lo) early++;
      n++;
      if (n == intrude) begin
        start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd3;
      end
      @(negedge clk);
      start = 1'b0; md_op = 3'd7;
    end
    chk({tag, " busy_cycles"}, 32'(n), 32'(n_exp));
    chk({tag, " hilo_early"}, 32'(early), 32'd0);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    total = 0; bad = 0;
    m_hi = 32'h0; m_lo = 32'h0;
    start = 1'b0; md_op = 3'd7; src_a = 32'h0; src_b = 32'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 0, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 32'h0000_0000, 32'h8000_0000);

    // MTHI/MTLO: immediate update, no Busy.
    start = 1'b1; md_op = 3'd5; src_a = 32'h22;
    @(negedge clk);
    chk("mtlo lo", lo, 32'h22);
    chk("mtlo busy", {31'h0, busy}, 32'h0);
    md_op = 3'd4; src_a = 32'h11;
    @(negedge clk);
    start = 1'b0; md_op = 3'd7;
    chk("mthi hi", hi, 32'h11);
    chk("mthi busy", {31'h0, busy}, 32'h0);
    m_hi = 32'h11; m_lo = 32'h22;

    run_op("divu_zero", 3'd3, 32'd7, 32'd0, 10, 0, 32'h11, 32'h22);

    start = 1'b1; md_op = 3'd5; src_a = 32'h1234;
    @(negedge clk);
    chk("mtlo2 lo", lo, 32'h1234);
    md_op = 3'd4; src_a = 32'h5678;
    @(negedge clk);
    chk("mthi2 hi", hi, 32'h5678);
    chk("mthi2 lo", lo, 32'h1234);
    chk("mt2 busy", {31'h0, busy}, 32'h0);
    // No-op opcode with Start changes nothing.
    md_op = 3'd6; src_a = 32'hDEAD_BEEF; src_b = 32'h1;
    @(negedge clk);
    start = 1'b0; md_op = 3'd7;
    chk("nop hi", hi, 32'h5678);
    chk("nop lo", lo, 32'h1234);
    chk("nop busy", {31'h0, busy}, 32'h0);
    m_hi = 32'h5678; m_lo = 32'h1234;

    // DIV with an intruding MULT Start during RUN: 100/7 -> q=14, r=2.
    run_op("div_intr", 3'd2, 32'd100, 32'd7, 10, 2, 32'd2, 32'd14);

    // Back-to-back: Start on the first cycle after Busy falls.
    run_op("b2b", 3'd0, 32'd6, 32'd7, 5, 0, 32'd0, 32'd42);

    // Async reset mid-RUN aborts with no commit.
    start = 1'b1; md_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = 3'd7;
    repeat (3) @(negedge clk);
    chk("pre_rst busy", {31'h0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst busy", {31'h0, busy}, 32'h0);
    chk("async_rst hi", hi, 32'h0);
    chk("async_rst lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst hi", hi, 32'h0);
    chk("post_rst lo", lo, 32'h0);
    chk("post_rst busy", {31'h0, busy}, 32'h0);
    m_hi = 32'h0; m_lo = 32'h0;

    run_op("mult_after_rst", 3'd0, 32'hFFFF_FFFD, 32'd5, 5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
